// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the divider display sequencer.
// State codes, display-mux select codes and select stepping.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_SHOW
  } state_t;

  localparam logic [1:0] SEL_NUM = 2'b00;
  localparam logic [1:0] SEL_DEN = 2'b01;
  localparam logic [1:0] SEL_COC = 2'b10;
  localparam logic [1:0] SEL_RES = 2'b11;

  // Result view: quotient, remainder, numerator, denominator, repeat
  function automatic logic [1:0] sel_step(input logic [1:0] s);
    logic [1:0] n;
    n = SEL_COC;
    case (s)
      SEL_COC: n = SEL_RES;
      SEL_RES: n = SEL_NUM;
      SEL_NUM: n = SEL_DEN;
      default: n = SEL_COC;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] sel_flip(input logic [1:0] s);
    return (s == SEL_NUM) ? SEL_DEN : SEL_NUM;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running cycle divider for display auto-scroll.
// Emits a one-cycle tick every SCROLL_CYC enabled cycles.
module tick_gen #(
  parameter int SCROLL_CYC = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (SCROLL_CYC > 2) ? $clog2(SCROLL_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(SCROLL_CYC - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en && !clr && w_last;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/div_display_ctrl.sv
// Button-driven sequencer for the 4-bit divider demo.
// Owns operand counters, divider handshake, watchdog and display select.
module div_display_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WAIT_MAX    = 64,
  parameter int AUTO_SCROLL = 0,
  parameter int SCROLL_CYC  = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_num,
  input  logic       btn_den,
  input  logic       btn_calc,
  input  logic       btn_view,
  input  logic       div_done,
  output logic [3:0] conta_num,
  output logic [3:0] conta_den,
  output logic       div_start,
  output logic [1:0] Sel,
  output logic       res_valid,
  output logic       div_zero,
  output logic       div_err
);

  localparam int WD_W = $clog2(WAIT_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

  state_t          r_state;
  logic [WD_W-1:0] r_wd;
  logic [3:0]      r_num;
  logic [3:0]      r_den;
  logic            r_start;
  logic [1:0]      r_sel;
  logic            r_valid;
  logic            r_zero;
  logic            r_err;

  logic w_show;
  logic w_en;
  logic w_clr;
  logic w_tick;

  assign w_show = (r_state == ST_SHOW);
  assign w_en   = (AUTO_SCROLL != 0) && w_show;
  assign w_clr  = w_show && btn_view;

  tick_gen #(
    .SCROLL_CYC(SCROLL_CYC)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wd    <= '0;
      r_num   <= '0;
      r_den   <= '0;
      r_start <= 1'b0;
      r_sel   <= SEL_NUM;
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_SHOW: begin
          if (btn_calc) begin
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            if (r_den == 4'd0) begin
              r_zero  <= 1'b1;
              r_sel   <= SEL_DEN;
              r_state <= ST_IDLE;
            end else begin
              r_zero  <= 1'b0;
              r_start <= 1'b1;
              r_state <= ST_START;
            end
          end else if (btn_num) begin
            r_num   <= r_num + 4'd1;
            r_sel   <= SEL_NUM;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else if (btn_den) begin
            r_den   <= r_den + 4'd1;
            r_sel   <= SEL_DEN;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else if (btn_view) begin
            r_sel <= w_show ? sel_step(r_sel) : sel_flip(r_sel);
          end else if (w_tick) begin
            r_sel <= sel_step(r_sel);
          end
        end
        ST_START: begin
          r_wd    <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done on the final allowed cycle still beats the watchdog
          if (div_done) begin
            r_valid <= 1'b1;
            r_sel   <= SEL_COC;
            r_state <= ST_SHOW;
          end else if (r_wd == WD_LAST) begin
            r_err   <= 1'b1;
            r_sel   <= SEL_NUM;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign conta_num = r_num;
  assign conta_den = r_den;
  assign div_start = r_start;
  assign Sel       = r_sel;
  assign res_valid = r_valid;
  assign div_zero  = r_zero;
  assign div_err   = r_err;

endmodule
